axi_stream_edit_header: RTL and testbench



---
 rtl/axi_stream_edit_header_if.sv | 38 +++
 rtl/axi_stream_edit_header.sv | 193 +++++++++++++++++++
 tb/tb_axi_stream_edit_header.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_edit_header_if.sv
// Bundled payload, output and header channels of axi_stream_edit_header.
// slave = the edit stage's view, master = the driving/consuming environment.
interface axi_stream_edit_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic                    ready_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;

    logic                    valid_out;
    logic                    ready_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;

    logic                    valid_insert;
    logic                    ready_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    mode_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
               valid_insert, data_insert, keep_insert, byte_insert_cnt, mode_insert,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
               valid_insert, data_insert, keep_insert, byte_insert_cnt, mode_insert,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );
endinterface

// File: rtl/axi_stream_edit_header.sv
// Per-packet header insert (1..DATA_BYTE_WD bytes) or, with AXIS_HDR_STRIP_EN
// defined, leading-byte strip; re-aligns the stream through a residual buffer.
module axi_stream_edit_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                     clk,
    input logic                     rst,
    axi_stream_edit_header_if.slave bus
);
    localparam int DW = DATA_WD;
    localparam int BW = DATA_BYTE_WD;
    localparam int CW = BYTE_CNT_WD + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PKT   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] res_q, res_d;
    logic [CW-1:0] res_cnt_q, res_cnt_d;
    logic          valid_out_q, valid_out_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [BW-1:0] keep_out_q, keep_out_d;
    logic          last_out_q, last_out_d;
`ifdef AXIS_HDR_STRIP_EN
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] drop_n;
`endif

    logic          out_free;
    logic          acc_in;
    logic          acc_hdr;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] total;
    logic [CW-1:0] hdr_n;
    logic [DW-1:0] data_masked;
    logic [2*DW-1:0] cat;

    function automatic logic [BW-1:0] keep_of(input logic [CW-1:0] cnt);
        logic [BW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < BW; i++)
            k[BW-1-i] = (CW'(i) < cnt);
        return k;
    endfunction

    assign out_free         = !valid_out_q || bus.ready_out;
    assign bus.ready_in     = (state_q == ST_PKT) && out_free;
    assign bus.ready_insert = (state_q == ST_IDLE) && !rst;
    assign acc_in           = bus.valid_in && bus.ready_in;
    assign acc_hdr          = bus.valid_insert && bus.ready_insert;

    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.keep_out  = keep_out_q;
    assign bus.last_out  = last_out_q;

    logic unused_sig;
`ifdef AXIS_HDR_STRIP_EN
    assign unused_sig = ^bus.keep_insert;
`else
    assign unused_sig = ^{bus.keep_insert, bus.mode_insert};
`endif

    // Byte string = residual (MSB-aligned, res_cnt bytes) followed by the valid beat bytes.
    always_comb begin
        beat_cnt    = '0;
        data_masked = '0;
        for (int unsigned i = 0; i < BW; i++) begin
            if (bus.keep_in[i]) begin
                beat_cnt                = beat_cnt + CW'(1);
                data_masked[i*8 +: 8]   = bus.data_in[i*8 +: 8];
            end
        end
        cat   = {res_q, {DW{1'b0}}} | ({data_masked, {DW{1'b0}}} >> {res_cnt_q, 3'b000});
        total = res_cnt_q + beat_cnt;
`ifdef AXIS_HDR_STRIP_EN
        // While dropping, the residual is always empty, so the drop only eats beat bytes.
        drop_n = drop_q;
        if (drop_q != '0) begin
            if (drop_q >= total) begin
                drop_n = drop_q - total;
                total  = '0;
                cat    = '0;
            end else begin
                cat    = cat << {drop_q, 3'b000};
                total  = total - drop_q;
                drop_n = '0;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        hdr_n       = CW'(bus.byte_insert_cnt) + CW'(1);
`ifdef AXIS_HDR_STRIP_EN
        drop_d      = drop_q;
`endif
        if (out_free)
            valid_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_hdr) begin
                    res_d     = bus.data_insert << {CW'(BW) - hdr_n, 3'b000};
                    res_cnt_d = hdr_n;
`ifdef AXIS_HDR_STRIP_EN
                    drop_d    = '0;
                    if (bus.mode_insert) begin
                        res_d     = '0;
                        res_cnt_d = '0;
                        drop_d    = hdr_n;
                    end
`endif
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                if (acc_in) begin
`ifdef AXIS_HDR_STRIP_EN
                    drop_d = drop_n;
`endif
                    if (total >= CW'(BW)) begin
                        valid_out_d = 1'b1;
                        data_out_d  = cat[2*DW-1 -: DW];
                        keep_out_d  = '1;
                        last_out_d  = bus.last_in && (total == CW'(BW));
                        res_d       = cat[DW-1:0];
                        res_cnt_d   = total - CW'(BW);
                    end else begin
                        res_d     = cat[2*DW-1 -: DW];
                        res_cnt_d = total;
                        if (bus.last_in && (total != '0)) begin
                            valid_out_d = 1'b1;
                            data_out_d  = cat[2*DW-1 -: DW];
                            keep_out_d  = keep_of(total);
                            last_out_d  = 1'b1;
                        end
                    end
                    if (bus.last_in)
                        state_d = (total > CW'(BW)) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = keep_of(res_cnt_q);
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            res_q       <= '0;
            res_cnt_q   <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
`ifdef AXIS_HDR_STRIP_EN
            drop_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
`ifdef AXIS_HDR_STRIP_EN
            drop_q      <= drop_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi_stream_edit_header.sv
// Bench for axi_stream_edit_header: byte-queue reference model, per-cycle output
// monitor, directed cases with literal expectations and randomized packets.
module tb_axi_stream_edit_header;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LIMIT = 2000;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned bp_mode = 0;
    beat_t       exp_q[$];
    beat_t       got_q[$];
    bq_t         pl;

    axi_stream_edit_header_if #(.DATA_WD(DW)) bus();
    axi_stream_edit_header #(.DATA_WD(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic logic [DW-1:0] kmask(input logic [BW-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < BW; j++)
            if (k[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound of %0d cycles expired without the awaited event", name, LIMIT);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "run stopped");
    endtask

    // Reference: header bytes (insert) or payload minus N leading bytes (strip), cut into beats.
    function automatic void model_push(input bit mode, input int unsigned n,
                                       input logic [DW-1:0] hdr, input bq_t p);
        bq_t o;
`ifndef AXIS_HDR_STRIP_EN
        mode = 1'b0;
`endif
        if (!mode) begin
            for (int i = int'(n) - 1; i >= 0; i--) o.push_back(hdr[8*i +: 8]);
            foreach (p[i]) o.push_back(p[i]);
        end else begin
            for (int i = int'(n); i < p.size(); i++) o.push_back(p[i]);
        end
        for (int b = 0; b * BW < o.size(); b++) begin
            beat_t t;
            t.data = '0;
            t.keep = '0;
            for (int j = 0; j < BW; j++) begin
                if (b * BW + j < o.size()) begin
                    t.data[DW-1-8*j -: 8] = o[b*BW+j];
                    t.keep[BW-1-j] = 1'b1;
                end
            end
            t.last = (b * BW + BW >= o.size());
            exp_q.push_back(t);
        end
    endfunction

    function automatic void add_bytes(input logic [31:0] w, input int unsigned n);
        for (int unsigned j = 0; j < n; j++) pl.push_back(w[31-8*j -: 8]);
    endfunction

    function automatic void chk_beat(input string name, input int unsigned i,
                                     input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        if (i >= got_q.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: beat %0d missing, got %0d beats", name, i, got_q.size());
        end else begin
            chk({name, "_data"}, 64'(got_q[i].data), 64'(d));
            chk({name, "_keep"}, 64'(got_q[i].keep), 64'(k));
            chk({name, "_last"}, 64'(got_q[i].last), 64'(l));
        end
    endfunction

    task automatic send_header(input bit mode, input int unsigned n, input logic [DW-1:0] hdr);
        int unsigned t;
        t = 0;
        bus.valid_insert    = 1'b1;
        bus.mode_insert     = mode;
        bus.byte_insert_cnt = 2'(n - 1);
        bus.data_insert     = hdr;
        bus.keep_insert     = 4'((1 << n) - 1);
        @(negedge clk);
        while (!bus.ready_insert) begin
            t++;
            if (t > LIMIT) abort("header_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        int unsigned t;
        t = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        @(negedge clk);
        while (!bus.ready_in) begin
            t++;
            if (t > LIMIT) abort("payload_wait");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic send_payload(input bq_t p, input bit gaps);
        int unsigned nb;
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        nb = (p.size() + BW - 1) / BW;
        if (nb == 0) nb = 1;
        for (int unsigned b = 0; b < nb; b++) begin
            d = $urandom;
            k = '0;
            for (int unsigned j = 0; j < BW; j++) begin
                if (b * BW + j < p.size()) begin
                    d[DW-1-8*j -: 8] = p[b*BW+j];
                    k[BW-1-j] = 1'b1;
                end
            end
            if (gaps) while ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(d, k, b == nb - 1);
        end
    endtask

    task automatic run_packet(input bit mode, input int unsigned n, input logic [DW-1:0] hdr,
                              input bq_t p, input bit gaps);
        model_push(mode, n, hdr, p);
        send_header(mode, n, hdr);
        send_payload(p, gaps);
    endtask

    task automatic wait_drain(input string name);
        int unsigned t;
        t = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            t++;
            if (t > LIMIT) abort(name);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshake checked against the model, stalls checked for stability.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic [BW-1:0] prev_k;
    logic          prev_l;
    beat_t         mon_e;
    beat_t         mon_g;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.valid_out), 64'(1));
                chk("stall_data", 64'(bus.data_out), 64'(prev_d));
                chk("stall_keep", 64'(bus.keep_out), 64'(prev_k));
                chk("stall_last", 64'(bus.last_out), 64'(prev_l));
            end
            if (bus.valid_out && !bus.ready_out)
                chk("stall_ready_in", 64'(bus.ready_in), 64'(0));
            if (bus.valid_out && bus.ready_out) begin
                mon_g.data = bus.data_out & kmask(bus.keep_out);
                mon_g.keep = bus.keep_out;
                mon_g.last = bus.last_out;
                got_q.push_back(mon_g);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %h keep %h last %0d, required no beat",
                             bus.data_out, bus.keep_out, bus.last_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", 64'(mon_g.data), 64'(mon_e.data));
                    chk("out_keep", 64'(mon_g.keep), 64'(mon_e.keep));
                    chk("out_last", 64'(mon_g.last), 64'(mon_e.last));
                end
            end
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_d     = bus.data_out;
            prev_k     = bus.keep_out;
            prev_l     = bus.last_out;
        end
    end

    initial begin
        bus.ready_out = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.ready_out = 1'b1;
                1:       bus.ready_out = ($urandom_range(0, 3) != 0);
                default: bus.ready_out = 1'b0;
            endcase
        end
    end

    initial begin
        #900000;
        abort("watchdog");
    end

    initial begin
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.last_in         = 1'b0;
        bus.valid_insert    = 1'b0;
        bus.data_insert     = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;
        bus.mode_insert     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("rst_data_out", 64'(bus.data_out), 64'(0));
        chk("rst_keep_out", 64'(bus.keep_out), 64'(0));
        chk("rst_last_out", 64'(bus.last_out), 64'(0));
        chk("rst_ready_in", 64'(bus.ready_in), 64'(0));
        chk("rst_ready_insert", 64'(bus.ready_insert), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready_insert", 64'(bus.ready_insert), 64'(1));

        // Insert cnt=1: header accepted at k, payload at k+1, output valid for the k+2 edge.
        got_q.delete();
        pl.delete();
        add_bytes(32'h11223344, 4);
        add_bytes(32'h55667788, 4);
        model_push(1'b0, 2, 32'h0000AABB, pl);
        send_header(1'b0, 2, 32'h0000AABB);
        bus.valid_in = 1'b1;
        bus.data_in  = 32'h11223344;
        bus.keep_in  = 4'hF;
        bus.last_in  = 1'b0;
        @(negedge clk);
        chk("ins_ready_in_k1", 64'(bus.ready_in), 64'(1));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        chk("ins_valid_out_k2", 64'(bus.valid_out), 64'(1));
        send_beat(32'h55667788, 4'hF, 1'b1);
        wait_drain("ins_drain");
        chk("ins_beats", 64'(got_q.size()), 64'(3));
        chk_beat("ins_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
        chk_beat("ins_b1", 1, 32'h33445566, 4'hF, 1'b0);
        chk_beat("ins_b2", 2, 32'h77880000, 4'hC, 1'b1);

`ifdef AXIS_HDR_STRIP_EN
        got_q.delete();
        pl.delete();
        add_bytes(32'h11223344, 4);
        add_bytes(32'h55660000, 2);
        run_packet(1'b1, 1, 32'h0, pl, 1'b0);
        wait_drain("strip_drain");
        chk("strip_beats", 64'(got_q.size()), 64'(2));
        chk_beat("strip_b0", 0, 32'h22334455, 4'hF, 1'b0);
        chk_beat("strip_b1", 1, 32'h66000000, 4'h8, 1'b1);

        got_q.delete();
        send_header(1'b1, 4, 32'h0);
        send_beat(32'h11223344, 4'hF, 1'b1);
        @(negedge clk);
        chk("fullstrip_ready_insert", 64'(bus.ready_insert), 64'(1));
        chk("fullstrip_valid_out", 64'(bus.valid_out), 64'(0));
        wait_drain("fullstrip_drain");
        chk("fullstrip_beats", 64'(got_q.size()), 64'(0));
`else
        got_q.delete();
        pl.delete();
        add_bytes(32'h11223344, 4);
        run_packet(1'b1, 1, 32'h000000CC, pl, 1'b0);
        wait_drain("nostrip_drain");
        chk("nostrip_beats", 64'(got_q.size()), 64'(2));
        chk_beat("nostrip_b0", 0, 32'hCC112233, 4'hF, 1'b0);
        chk_beat("nostrip_b1", 1, 32'h44000000, 4'h8, 1'b1);
`endif

        // Backpressure: ready_out forced low for 3 cycles mid-packet.
        got_q.delete();
        pl.delete();
        add_bytes(32'h01020304, 4);
        add_bytes(32'h05060708, 4);
        add_bytes(32'h090A0B0C, 4);
        fork
            run_packet(1'b0, 3, 32'h00D1D2D3, pl, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                bp_mode = 2;
                repeat (3) @(posedge clk);
                #1;
                bp_mode = 0;
            end
        join
        wait_drain("bp_drain");
        chk("bp_beats", 64'(got_q.size()), 64'(4));
        chk_beat("bp_b0", 0, 32'hD1D2D301, 4'hF, 1'b0);
        chk_beat("bp_b3", 3, 32'h0A0B0C00, 4'hE, 1'b1);

        // Reset mid-packet after two beats.
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'(i + 16));
        model_push(1'b0, 2, 32'h0000AABB, pl);
        send_header(1'b0, 2, 32'h0000AABB);
        send_beat(32'h10111213, 4'hF, 1'b0);
        send_beat(32'h14151617, 4'hF, 1'b0);
        #2;
        chk("pre_reset_valid", 64'(bus.valid_out), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_valid_out", 64'(bus.valid_out), 64'(0));
        chk("midrst_data_out", 64'(bus.data_out), 64'(0));
        chk("midrst_keep_out", 64'(bus.keep_out), 64'(0));
        chk("midrst_last_out", 64'(bus.last_out), 64'(0));
        chk("midrst_ready_in", 64'(bus.ready_in), 64'(0));
        chk("midrst_ready_insert", 64'(bus.ready_insert), 64'(0));
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        got_q.delete();
        pl.delete();
        add_bytes(32'hC0C1C2C3, 4);
        add_bytes(32'hC4000000, 1);
        run_packet(1'b0, 4, 32'hE0E1E2E3, pl, 1'b0);
        wait_drain("postrst_drain");
        chk("postrst_beats", 64'(got_q.size()), 64'(3));
        chk_beat("postrst_b0", 0, 32'hE0E1E2E3, 4'hF, 1'b0);
        chk_beat("postrst_b2", 2, 32'hC4000000, 4'h8, 1'b1);

        // Randomized packets, modes, counts, lengths, gaps and backpressure.
        for (int p = 0; p < 200; p++) begin
            bit          m;
            int unsigned n;
            int unsigned len;
            m   = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, BW);
            len = $urandom_range(0, 13);
            pl.delete();
            for (int i = 0; i < int'(len); i++) pl.push_back(8'($urandom));
            bp_mode = $urandom_range(0, 1);
            run_packet(m, n, $urandom, pl, 1'($urandom_range(0, 1)));
        end
        bp_mode = 0;
        wait_drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
